// File: rtl/fir_pkg.sv
// Shared parameters, state encoding and default coefficient table for the
// sequenced FIR filter controller (fir_seq_ctrl) and its MAC datapath (fir_mac).
package fir_pkg;

  localparam int FIR_DATA_WIDTH = 8;
  localparam int FIR_NUM_TAPS   = 4;
  localparam int FIR_ACC_WIDTH  = 2 * FIR_DATA_WIDTH + $clog2(FIR_NUM_TAPS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    MAC   = 2'd2,
    OUT   = 2'd3
  } fir_state_e;

  localparam int FIR_DEFAULT_COEF [FIR_NUM_TAPS] = '{1, 2, 3, 4};

  // Instances with more taps than the table continue the same ramp.
  function automatic int fir_default_coef(input int idx);
    if (idx < FIR_NUM_TAPS) begin
      return FIR_DEFAULT_COEF[idx];
    end
    return idx + 1;
  endfunction

endpackage

// File: rtl/fir_mac.sv
// Signed multiply-accumulate datapath: clear has priority over enable, the
// product is kept at full precision and added without saturation.
module fir_mac
  import fir_pkg::*;
#(
  parameter int DATA_WIDTH = FIR_DATA_WIDTH,
  parameter int ACC_WIDTH  = FIR_ACC_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear_i,
  input  logic                         en_i,
  input  logic signed [DATA_WIDTH-1:0] sample_i,
  input  logic signed [DATA_WIDTH-1:0] coef_i,
  output logic signed [ACC_WIDTH-1:0]  acc_o
);

  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0]    acc_q;
  logic signed [ACC_WIDTH-1:0]    acc_d;

  always_comb begin
    prod  = (2*DATA_WIDTH)'(sample_i) * (2*DATA_WIDTH)'(coef_i);
    acc_d = acc_q;
    if (clear_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + ACC_WIDTH'(prod);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/fir_seq_ctrl.sv
// Sequencer for a time-multiplexed FIR filter: accepts a sample, advances the
// external shift register, walks every tap through fir_mac, then holds the result.
// Define FIR_COEF_LOAD_EN to add a writable coefficient register file.
module fir_seq_ctrl
  import fir_pkg::*;
#(
  parameter int  DATA_WIDTH = FIR_DATA_WIDTH,
  parameter int  NUM_TAPS   = FIR_NUM_TAPS,
  parameter int  ACC_WIDTH  = 2 * DATA_WIDTH + $clog2(NUM_TAPS),
  localparam int TAP_W      = $clog2(NUM_TAPS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  output logic                         in_ready,
  output logic                         sr_shift_en,
  output logic signed [DATA_WIDTH-1:0] sr_data,
  output logic [TAP_W-1:0]             tap_sel,
  input  logic signed [DATA_WIDTH-1:0] tap_data,
  output logic                         out_valid,
  output logic signed [ACC_WIDTH-1:0]  out_data,
  input  logic                         out_ready,
`ifdef FIR_COEF_LOAD_EN
  input  logic                         coef_we,
  input  logic [TAP_W-1:0]             coef_addr,
  input  logic signed [DATA_WIDTH-1:0] coef_wdata,
`endif
  output logic                         busy
);

  fir_state_e                   state_q, state_d;
  logic [TAP_W-1:0]             tap_idx_q, tap_idx_d;
  logic signed [DATA_WIDTH-1:0] sample_q, sample_d;
  logic                         mac_clear;
  logic                         mac_en;
  logic                         last_tap;
  logic signed [DATA_WIDTH-1:0] coef [NUM_TAPS];

  assign last_tap = (tap_idx_q == TAP_W'(NUM_TAPS - 1));

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      tap_idx_q <= '0;
      sample_q  <= '0;
    end else begin
      state_q   <= state_d;
      tap_idx_q <= tap_idx_d;
      sample_q  <= sample_d;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    tap_idx_d   = tap_idx_q;
    sample_d    = sample_q;
    mac_clear   = 1'b0;
    mac_en      = 1'b0;
    in_ready    = 1'b0;
    sr_shift_en = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b1;
    tap_sel     = '0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          sample_d = in_data;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        sr_shift_en = 1'b1;
        mac_clear   = 1'b1;
        tap_idx_d   = '0;
        state_d     = MAC;
      end
      MAC: begin
        tap_sel = tap_idx_q;
        mac_en  = 1'b1;
        if (last_tap) begin
          tap_idx_d = '0;
          state_d   = OUT;
        end else begin
          tap_idx_d = tap_idx_q + TAP_W'(1);
        end
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign sr_data = sample_q;

`ifdef FIR_COEF_LOAD_EN
  logic signed [DATA_WIDTH-1:0] coef_q [NUM_TAPS];

  // NOTE: this small register file is reset deliberately so rst restores the default taps.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_TAPS; k++) begin
        coef_q[k] <= DATA_WIDTH'(fir_default_coef(k));
      end
    end else if (coef_we && (state_q == IDLE)) begin
      coef_q[coef_addr] <= coef_wdata;
    end
  end

  assign coef = coef_q;
`else
  always_comb begin
    for (int k = 0; k < NUM_TAPS; k++) begin
      coef[k] = DATA_WIDTH'(fir_default_coef(k));
    end
  end
`endif

  fir_mac #(
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_mac (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (mac_clear),
    .en_i     (mac_en),
    .sample_i (tap_data),
    .coef_i   (coef[tap_idx_q]),
    .acc_o    (out_data)
  );

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Self-checking bench for fir_seq_ctrl: the bench owns the sample shift register
// and predicts every output from the list of accepted samples and coefficients.
module tb_fir_seq_ctrl;

  localparam int DW = 8;
  localparam int N  = 4;
  localparam int TW = $clog2(N);
  localparam int AW = 2 * DW + TW;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic signed [DW-1:0] in_data;
  logic                 in_ready;
  logic                 sr_shift_en;
  logic signed [DW-1:0] sr_data;
  logic [TW-1:0]        tap_sel;
  logic signed [DW-1:0] tap_data;
  logic                 out_valid;
  logic signed [AW-1:0] out_data;
  logic                 out_ready;
  logic                 busy;
`ifdef FIR_COEF_LOAD_EN
  logic                 coef_we;
  logic [TW-1:0]        coef_addr;
  logic signed [DW-1:0] coef_wdata;
`endif

  always #5 clk = ~clk;

  fir_seq_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .sr_shift_en (sr_shift_en),
    .sr_data     (sr_data),
    .tap_sel     (tap_sel),
    .tap_data    (tap_data),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
`ifdef FIR_COEF_LOAD_EN
    .coef_we     (coef_we),
    .coef_addr   (coef_addr),
    .coef_wdata  (coef_wdata),
`endif
    .busy        (busy)
  );

  // Sample shift register that the controller drives: stage 0 is the newest sample.
  logic signed [DW-1:0] sr [N];
  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N; k++) sr[k] <= '0;
    end else if (sr_shift_en) begin
      sr[0] <= sr_data;
      for (int k = 1; k < N; k++) sr[k] <= sr[k-1];
    end
  end
  assign tap_data = sr[tap_sel];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: phase 0 idle, 1 shift, 2..N+1 tap walk, N+2 result held.
  int                   ph;
  bit                   model_on;
  logic signed [DW-1:0] hist [$];
  int                   coef_m [N];
  longint               results [$];
  int                   shift_cnt;
  int                   shift_cyc;
  int                   first_ov_cyc;
  bit                   ov_prev;

  function automatic longint expected_out();
    longint s = 0;
    for (int k = 0; k < N; k++) begin
      if (k < hist.size()) s += longint'(coef_m[k]) * longint'(hist[k]);
    end
    return s;
  endfunction

  initial begin
    ph           = 0;
    model_on     = 1'b0;
    shift_cnt    = 0;
    shift_cyc    = 0;
    first_ov_cyc = 0;
    ov_prev      = 1'b0;
    coef_m       = '{1, 2, 3, 4};
    forever begin
      @(negedge clk);
      if (model_on) begin
        check("in_ready", in_ready, ph == 0);
        check("busy", busy, ph != 0);
        check("sr_shift_en", sr_shift_en, ph == 1);
        check("tap_sel", tap_sel, (ph >= 2 && ph <= N + 1) ? ph - 2 : 0);
        check("out_valid", out_valid, ph == N + 2);
        if (ph == 1) check("sr_data", sr_data, hist[0]);
        if (ph == N + 2) check("out_data", out_data, expected_out());
        if (sr_shift_en === 1'b1) begin
          shift_cnt++;
          shift_cyc = cyc + 1;
        end
        if (out_valid === 1'b1 && !ov_prev) first_ov_cyc = cyc + 1;
        if (out_valid === 1'b1 && out_ready) results.push_back(out_data);
        ov_prev = (out_valid === 1'b1);
      end
      // Predict the effect of the coming rising edge.
      if (rst) begin
        model_on = 1'b1;
        ph       = 0;
        hist.delete();
        coef_m   = '{1, 2, 3, 4};
      end else if (model_on) begin
        if (ph == 0) begin
`ifdef FIR_COEF_LOAD_EN
          if (coef_we) coef_m[coef_addr] = coef_wdata;
`endif
          if (in_valid) begin
            hist.push_front(in_data);
            if (hist.size() > N) void'(hist.pop_back());
            ph = 1;
          end
        end else if (ph <= N + 1) begin
          ph++;
        end else if (out_ready) begin
          ph = 0;
        end
      end
    end
  end

  int acc_cyc;

  task automatic send(input int s);
    bit ok = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = DW'(s);
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
    end
    #1;
    in_valid = 1'b0;
    acc_cyc  = cyc;
    check("sample accepted", ok, 1);
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
    end
    check("returned to idle", ok, 1);
  endtask

`ifdef FIR_COEF_LOAD_EN
  task automatic write_coef(input int addr, input int val);
    @(posedge clk);
    #1;
    coef_we    = 1'b1;
    coef_addr  = TW'(addr);
    coef_wdata = DW'(val);
    @(posedge clk);
    #1;
    coef_we    = 1'b0;
  endtask
`endif

  initial begin
    bit ok;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
`ifdef FIR_COEF_LOAD_EN
    coef_we    = 1'b0;
    coef_addr  = '0;
    coef_wdata = '0;
`endif
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset in_ready", in_ready, 1);
    check("reset out_valid", out_valid, 0);
    check("reset busy", busy, 0);
    check("reset sr_shift_en", sr_shift_en, 0);
    check("reset tap_sel", tap_sel, 0);

    // Impulse response with default coefficients.
    results.delete();
    send(1);
    for (int i = 0; i < 4; i++) send(0);
    wait_idle();
    check("impulse count", results.size(), 5);
    check("impulse y0", results[0], 1);
    check("impulse y1", results[1], 2);
    check("impulse y2", results[2], 3);
    check("impulse y3", results[3], 4);
    check("impulse y4", results[4], 0);

    // Latency of a single sample; shift register holds zeros beforehand.
    results.delete();
    shift_cnt = 0;
    send(5);
    wait_idle();
    check("latency out_valid", first_ov_cyc - acc_cyc, 6);
    check("latency shift cycle", shift_cyc - acc_cyc, 1);
    check("shift strobe count", shift_cnt, 1);
    check("single sample y", results[0], 5);

    // Backpressure: result held, new samples ignored. Stages become 2,5,0,0.
    results.delete();
    out_ready = 1'b0;
    send(2);
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      ok = out_valid;
    end
    check("out_valid reached", ok, 1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      in_valid = i[0];
      in_data  = 8'sd99;
      @(negedge clk);
      check("bp out_data", out_data, 12);
      check("bp in_ready", in_ready, 0);
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("release out_valid", out_valid, 1);
    @(negedge clk);
    check("release in_ready", in_ready, 1);
    check("bp result count", results.size(), 1);

    // Signed extremes through the default taps.
    results.delete();
    for (int i = 0; i < 4; i++) send(-128);
    send(127);
    wait_idle();
    check("all -128 y", results[3], -1280);
    check("127 after -128s y", results[4], -1025);

    // Reset while the tap walk is at index 2.
    results.delete();
    send(3);
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      ok = (tap_sel == TW'(1));
    end
    check("mac tap 1 reached", ok, 1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("mid-mac tap_sel", tap_sel, 2);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post-reset in_ready", in_ready, 1);
    check("post-reset out_valid", out_valid, 0);
    repeat (10) @(negedge clk);
    check("no result after reset", results.size(), 0);
    send(1);
    wait_idle();
    check("post-reset impulse count", results.size(), 1);
    check("post-reset impulse y0", results[0], 1);

`ifdef FIR_COEF_LOAD_EN
    // Coefficient load in idle; a write during the tap walk must be dropped.
    for (int i = 0; i < 4; i++) send(0);
    wait_idle();
    write_coef(3, 7);
    results.delete();
    send(1);
    @(posedge clk);
    #1;
    coef_we    = 1'b1;
    coef_addr  = TW'(3);
    coef_wdata = 8'sd9;
    @(posedge clk);
    #1;
    coef_we    = 1'b0;
    for (int i = 0; i < 3; i++) send(0);
    wait_idle();
    check("load impulse y0", results[0], 1);
    check("load impulse y1", results[1], 2);
    check("load impulse y2", results[2], 3);
    check("load impulse y3", results[3], 7);

    // Most negative samples against most negative coefficients.
    for (int k = 0; k < 4; k++) write_coef(k, -128);
    results.delete();
    for (int i = 0; i < 4; i++) send(-128);
    wait_idle();
    check("extreme y", results[3], 65536);
`endif

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish, %0d failed so far", n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fir_seq_ctrl.md
FIR_SEQ_CTRL -- requirements
Module: fir_seq_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, 8: signed sample and coefficient width.
REQ-002 Parameter NUM_TAPS, 4: number of filter taps and shift-register stages (>=2).
REQ-003 Parameter ACC_WIDTH, 2*DATA_WIDTH+$clog2(NUM_TAPS): accumulator and result width.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 in_valid  in  1  input sample offered.
REQ-007 in_data  in  DATA_WIDTH  signed input sample.
REQ-008 in_ready  out  1  controller accepts sample; equals (state==IDLE).
REQ-009 sr_shift_en  out  1  one-cycle advance strobe to the sample shift register.
REQ-010 sr_data  out  DATA_WIDTH  captured sample presented to the shift register serial input.
REQ-011 tap_sel  out  $clog2(NUM_TAPS)  index of the shift-register stage being read.
REQ-012 tap_data  in  DATA_WIDTH  signed value of stage tap_sel, valid in the same cycle.
REQ-013 out_valid  out  1  filter result available.
REQ-014 out_data  out  ACC_WIDTH  signed filter result.
REQ-015 out_ready  in  1  downstream accepts result.
REQ-016 busy  out  1  high in every state except IDLE.

Function
REQ-017 States IDLE, SHIFT, MAC, OUT; encoding per the package enum.
REQ-018 IDLE: in_valid&&in_ready captures in_data into sample register, next state SHIFT.
REQ-019 SHIFT (1 cycle): sr_shift_en=1, sr_data=captured sample; next MAC with tap_idx=0 and accumulator cleared.
REQ-020 MAC: tap_sel=tap_idx; each cycle acc <= acc + tap_data*coef[tap_idx], signed, full precision, no saturation.
REQ-021 MAC: tap_idx increments each cycle; after the tap_idx==NUM_TAPS-1 update, next state OUT.
REQ-022 OUT: out_valid=1, out_data=acc held stable until out_valid&&out_ready, then IDLE.
REQ-023 Latency: sample accepted at edge T -> out_valid first high in cycle T+NUM_TAPS+2; throughput one sample per NUM_TAPS+3 cycles with out_ready held high.
REQ-024 in_valid while not IDLE is ignored; no sample is lost as in_ready is low.
REQ-025 sr_shift_en SHALL be low in every state except SHIFT; tap_sel SHALL be 0 outside MAC.
REQ-026 Tap 0 is the newest sample; stage k holds the sample accepted k samples earlier.

Reset
REQ-027 rst forces IDLE, tap_idx=0, acc=0, sample register=0, out_valid=0, sr_shift_en=0, in_ready=1 on the next edge.
REQ-028 rst mid-MAC or mid-OUT discards the partial/pending result; no out_valid after reset until a new sample completes.
REQ-029 rst has priority over every handshake in the same cycle.

Configuration
REQ-030 Macro FIR_COEF_LOAD_EN defined: ports coef_we(1), coef_addr($clog2(NUM_TAPS)), coef_wdata(DATA_WIDTH) write a coefficient register file; writes honoured only in IDLE, ignored otherwise; rst loads package default coefficients.
REQ-031 FIR_COEF_LOAD_EN undefined: ports absent; coefficients are the package default constant table.

Structure
REQ-032 Shared package fir_pkg holds DATA_WIDTH, NUM_TAPS, ACC_WIDTH defaults, state enum, default coefficient array (1,2,3,4 for NUM_TAPS=4).
REQ-033 Sub-module fir_mac (clear, enable, signed multiply-accumulate) is instantiated for REQ-020; FSM and counters live in fir_seq_ctrl.

Verification
REQ-034 Impulse: samples 1,0,0,0,0 with default coefficients -> out_data sequence 1,2,3,4,0.
REQ-035 Latency: single sample accepted at edge T, out_ready=1 -> out_valid at cycle T+6 (NUM_TAPS=4), sr_shift_en exactly one cycle at T+1.
REQ-036 Backpressure: out_ready=0 for 10 cycles in OUT -> out_data stable, in_ready=0, in_valid pulses ignored; release -> IDLE next cycle.
REQ-037 Signed extremes: all stages -128, coefficients -128 (load enabled) -> out_data = 65536 without overflow.
REQ-038 Reset mid-MAC (tap_idx=2) -> IDLE next edge, out_valid stays 0, following impulse gives 1 first.
REQ-039 FIR_COEF_LOAD_EN: write coef[3]=7 in IDLE, attempted write during MAC ignored -> impulse response 1,2,3,7.
